// File: rtl/vector_packer.sv
// vector_packer
//   Packs a scalar stream of (A, B) operand pairs into VECTOR_SIZE-lane
//   vectors for multiply_and_accumulate. Each vector is emitted as a
//   one-cycle strobe on validOut (per-lane mask) with lastOut marking the
//   vector that closes a dot product. There is no backpressure.
//
//   Optional build macro: VECTOR_PACKER_ZERO_PAD_EN
//     defined   - lanes outside the valid mask are driven as zero
//     undefined - lanes outside the valid mask carry stale buffer contents
//
// Ports
//   clkIn        clock, rising edge
//   rstIn        asynchronous active-low reset
//   dataAIn      scalar operand A
//   dataBIn      scalar operand B
//   validIn      A/B pair valid this cycle
//   lastIn       final element of the dot product (qualified by validIn)
//   dataAOut     packed A vector, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   dataBOut     packed B vector, same layout
//   validOut     per-lane valid mask, nonzero only on the emit cycle
//   lastOut      emitted vector closes the dot product
//   vecCountOut  vectors emitted in the dot product currently in progress

module vector_packer #(
  parameter int unsigned VECTOR_SIZE = 8,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                              clkIn,
  input  logic                              rstIn,
  input  logic [DATA_WIDTH-1:0]             dataAIn,
  input  logic [DATA_WIDTH-1:0]             dataBIn,
  input  logic                              validIn,
  input  logic                              lastIn,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] dataAOut,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] dataBOut,
  output logic [VECTOR_SIZE-1:0]            validOut,
  output logic                              lastOut,
  output logic [15:0]                       vecCountOut
);

  localparam int unsigned IDX_W = $clog2(VECTOR_SIZE);
  localparam int unsigned VW    = VECTOR_SIZE * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [VECTOR_SIZE-1:0] mask;
  logic [VW-1:0]          buf_a;
  logic [VW-1:0]          buf_b;

  // Captured vector waiting one cycle before it is driven onto the outputs.
  logic                   pend;
  logic                   pend_last;
  logic [VECTOR_SIZE-1:0] pend_mask;

  logic [IDX_W-1:0]       wr_idx;
  logic [VECTOR_SIZE-1:0] lane_bit;
  logic                   flush;
  logic [VW-1:0]          emit_a;
  logic [VW-1:0]          emit_b;

  // In IDLE the fill is empty, so the element always lands in lane 0.
  always_comb begin
    wr_idx   = (state == IDLE) ? '0 : idx;
    lane_bit = '0;
    for (int unsigned k = 0; k < VECTOR_SIZE; k++) begin
      lane_bit[k] = (wr_idx == IDX_W'(k));
    end
    flush = validIn && ((wr_idx == LAST_IDX) || lastIn);
  end

  // The buffer is read on the same edge a following element may overwrite
  // lane 0; non-blocking update keeps the emitted vector intact.
  always_comb begin
    emit_a = buf_a;
    emit_b = buf_b;
`ifdef VECTOR_PACKER_ZERO_PAD_EN
    for (int unsigned k = 0; k < VECTOR_SIZE; k++) begin
      if (!pend_mask[k]) begin
        emit_a[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        emit_b[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state       <= IDLE;
      idx         <= '0;
      mask        <= '0;
      buf_a       <= '0;
      buf_b       <= '0;
      pend        <= 1'b0;
      pend_last   <= 1'b0;
      pend_mask   <= '0;
      dataAOut    <= '0;
      dataBOut    <= '0;
      validOut    <= '0;
      lastOut     <= 1'b0;
      vecCountOut <= '0;
    end else begin
      validOut <= '0;
      lastOut  <= 1'b0;
      pend     <= 1'b0;

      if (pend) begin
        dataAOut    <= emit_a;
        dataBOut    <= emit_b;
        validOut    <= pend_mask;
        lastOut     <= pend_last;
        vecCountOut <= pend_last ? '0 : vecCountOut + 16'd1;
      end

      if (validIn) begin
        for (int unsigned k = 0; k < VECTOR_SIZE; k++) begin
          if (lane_bit[k]) begin
            buf_a[k*DATA_WIDTH +: DATA_WIDTH] <= dataAIn;
            buf_b[k*DATA_WIDTH +: DATA_WIDTH] <= dataBIn;
          end
        end

        if (flush) begin
          pend      <= 1'b1;
          pend_mask <= mask | lane_bit;
          pend_last <= lastIn;
          idx       <= '0;
          mask      <= '0;
          state     <= IDLE;
        end else begin
          idx   <= wr_idx + IDX_W'(1);
          mask  <= mask | lane_bit;
          state <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_packer.sv
module tb_vector_packer;

  localparam int unsigned VS = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned VW = VS * DW;
`ifdef VECTOR_PACKER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clkIn;
  logic          rstIn;
  logic [DW-1:0] dataAIn;
  logic [DW-1:0] dataBIn;
  logic          validIn;
  logic          lastIn;
  logic [VW-1:0] dataAOut;
  logic [VW-1:0] dataBOut;
  logic [VS-1:0] validOut;
  logic          lastOut;
  logic [15:0]   vecCountOut;

  vector_packer #(.VECTOR_SIZE(VS), .DATA_WIDTH(DW)) dut (
    .clkIn       (clkIn),
    .rstIn       (rstIn),
    .dataAIn     (dataAIn),
    .dataBIn     (dataBIn),
    .validIn     (validIn),
    .lastIn      (lastIn),
    .dataAOut    (dataAOut),
    .dataBOut    (dataBOut),
    .validOut    (validOut),
    .lastOut     (lastOut),
    .vecCountOut (vecCountOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: elements of the open vector in a queue, last-seen lane
  // contents in arrays, and a vector waiting to appear after the next edge.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] sa[VS];
  logic [DW-1:0] sb[VS];
  bit            pend;
  logic [VW-1:0] pa, pb;
  logic [VS-1:0] pm;
  bit            pl;
  logic [VW-1:0] exp_a, exp_b;
  logic [VS-1:0] exp_v;
  bit            exp_l;
  logic [15:0]   exp_cnt;

  task automatic model_reset();
    qa.delete(); qb.delete();
    for (int k = 0; k < VS; k++) begin sa[k] = '0; sb[k] = '0; end
    pend = 0; pa = '0; pb = '0; pm = '0; pl = 0;
    exp_a = '0; exp_b = '0; exp_v = '0; exp_l = 0; exp_cnt = '0;
  endtask

  task automatic model_edge(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit l);
    int n;
    if (pend) begin
      exp_a = pa; exp_b = pb; exp_v = pm; exp_l = pl;
      exp_cnt = pl ? 16'd0 : exp_cnt + 16'd1;
      pend = 0;
    end else begin
      exp_v = '0; exp_l = 0;
    end
    if (v) begin
      qa.push_back(a); qb.push_back(b);
      if (qa.size() == VS || l) begin
        n = qa.size();
        for (int k = 0; k < n; k++) begin sa[k] = qa[k]; sb[k] = qb[k]; end
        for (int k = 0; k < VS; k++) begin
          pa[k*DW +: DW] = (PAD && k >= n) ? '0 : sa[k];
          pb[k*DW +: DW] = (PAD && k >= n) ? '0 : sb[k];
          pm[k] = (k < n);
        end
        pl = l;
        pend = 1;
        qa.delete(); qb.delete();
      end
    end
  endtask

  task automatic check_all();
    check("validOut", VW'(validOut), VW'(exp_v));
    check("lastOut", VW'(lastOut), VW'(exp_l));
    check("vecCountOut", VW'(vecCountOut), VW'(exp_cnt));
    check("dataAOut", dataAOut, exp_a);
    check("dataBOut", dataBOut, exp_b);
  endtask

  // Called at a negedge: drive, clock, update model, check at next negedge.
  task automatic step(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit l);
    validIn = v; dataAIn = a; dataBIn = b; lastIn = l;
    @(posedge clkIn);
    if (!rstIn) model_reset();
    else model_edge(v, a, b, l);
    @(negedge clkIn);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom, $urandom, 0);
  endtask

  int cnt;

  initial begin
    rstIn = 1'b0; validIn = 0; lastIn = 0; dataAIn = '0; dataBIn = '0;
    model_reset();
    @(negedge clkIn);

    // Reset held for 100 ns with validIn toggling
    for (int i = 0; i < 10; i++) step(i[0], $urandom, $urandom, 1);
    rstIn = 1'b1;

    // First element 1/2 then 7 more; emit only after the 8th
    step(1, 32'h1, 32'h2, 0);
    for (int i = 0; i < 7; i++) step(1, $urandom, $urandom, 0);
    idle(3);

    // Full vector with last on the 8th element
    for (int i = 0; i < 8; i++) step(1, DW'(i + 1), DW'(32'h10 + i), i == 7);
    step(0, 0, 0, 0);
    check("full_lane0_A", VW'(dataAOut[0 +: DW]), VW'(32'h1));
    check("full_lane7_A", VW'(dataAOut[7*DW +: DW]), VW'(32'h8));
    idle(2);

    // 19 continuous elements, last on the 19th: 0xFF, 0xFF, 0x07
    for (int i = 0; i < 19; i++) step(1, $urandom, $urandom, i == 18);
    idle(3);

    // Full 0xAAAAAAAA vector, then a 3-element vector with last
    for (int i = 0; i < 8; i++) step(1, 32'hAAAAAAAA, 32'hAAAAAAAA, 0);
    for (int i = 0; i < 3; i++) step(1, DW'(i + 100), DW'(i + 200), i == 2);
    step(0, 0, 0, 0);
    check("pad_lane3_A", VW'(dataAOut[3*DW +: DW]), PAD ? '0 : VW'(32'hAAAAAAAA));
    check("pad_lane7_B", VW'(dataBOut[7*DW +: DW]), PAD ? '0 : VW'(32'hAAAAAAAA));
    check("pad_valid", VW'(validOut), VW'(8'h07));
    idle(2);

    // Gapped input with a lastIn pulse on an invalid cycle
    cnt = 0;
    while (cnt < 8) begin
      if (cnt == 3) step(0, $urandom, $urandom, 1);
      if ($urandom_range(0, 2) == 0) step(0, $urandom, $urandom, $urandom_range(0, 1));
      else begin
        step(1, DW'(cnt + 32'h50), DW'(cnt + 32'h60), 0);
        cnt++;
      end
    end
    idle(3);

    // Asynchronous reset mid-fill after 5 elements
    for (int i = 0; i < 5; i++) step(1, $urandom, $urandom, 0);
    #2 rstIn = 1'b0;
    #1 model_reset();
    check_all();
    for (int i = 0; i < 3; i++) step(i[0], $urandom, $urandom, 0);
    rstIn = 1'b1;
    idle(2);
    for (int i = 0; i < 8; i++) step(1, DW'(i + 32'h70), DW'(i + 32'h80), 0);
    idle(2);

    // Randomized gapped stream with random last markers
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 9) == 0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
